mul8_seq: RTL
=============

Name: mul8_seq

Overview:
- Sequential 8x8 shift-and-add multiplier for the RISC-V datapath.
- Sits directly upstream of the 8-bit ripple-carry adder and time-shares it:
  - drives the adder operand and carry-in ports every cycle;
  - consumes its sum and carry-out to build a 16-bit product over 8 iterations.
- Lets the core reuse the existing adder instead of instantiating a combinational array multiplier.

Parameters:
- WIDTH, 8, operand width. Fixed to match the adder; other values unsupported.
- ITER, 8, iteration count. Must equal WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only on a rising edge where busy=0.
- a  input  8  multiplicand, sampled on the accepting edge.
- b  input  8  multiplier, sampled on the accepting edge.
- busy  output  1  high while state=RUN.
- done  output  1  one-cycle pulse: product is valid.
- product  output  16  result register; holds until the next accepted start.
- add_a  output  8  to adder A.
- add_b  output  8  to adder B.
- add_ci  output  1  to adder CI; constant 0.
- add_y  input  8  from adder Y.
- add_c  input  1  from adder C.
- Adder V output is unused.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Polarity and synchronicity are fixed.
- Reset: state=IDLE, busy=0, done=0, product=16'h0000; acc, mq, mcand and count cleared. Reset asserted mid-operation aborts with no done pulse; reset has priority over start.
- Internal registers: acc[7:0] (high half), mq[7:0] (multiplier/low half), mcand[7:0], count[3:0].
- States: IDLE, RUN, DONE.
- IDLE or DONE, with start=1:
  - acc<=0, mq<=b, mcand<=a, count<=0, next state RUN.
  - product is unchanged.
  - start while busy=1 is ignored and has no side effects.
- RUN, every edge:
  - {acc,mq} <= {add_c, add_y, mq[7:1]}.
  - count<=count+1.
  - When count==7, next state DONE and product<={add_c, add_y, mq[7:1]} (the same value loaded into {acc,mq}).
- DONE: done=1 for exactly one cycle. Next state IDLE, or RUN if start=1 on that edge (back-to-back).
- Adder drive (combinational, every state):
  - add_a=acc.
  - add_b = (state==RUN && mq[0]) ? mcand : 8'h00.
  - add_ci=0.
  - In IDLE/DONE the adder output is don't-care.
- Latency:
  - busy=1 for exactly 8 cycles after the accepting edge.
  - done is high in the 9th cycle, beginning 8 edges after acceptance.
  - Throughput: one result per 9 cycles.
- Arithmetic: unsigned by default. The product is always the exact 16-bit result, so there is no overflow. add_c is the 9th bit of each partial sum.
- Operands a and b may change freely after the accepting edge.

Optional Feature:
- Macro: MUL8_SIGNED_EN
- Defined: operands are two's complement.
  - On accept: mcand<=|a|, mq<=|b| (8-bit magnitude; -128 maps to 8'h80), and sign<=a[7]^b[7].
  - On the completion edge: product<= sign ? -{add_c,add_y,mq[7:1]} : {add_c,add_y,mq[7:1]} (16-bit two's-complement negate, internal logic, not the shared adder).
  - Latency is unchanged.
- Undefined: pure unsigned; no sign register or negation logic is synthesised.

Test Plan:
- a=13, b=11, start pulse -> busy high 8 cycles; done single pulse; product=16'h008F, held after done.
- a=255, b=255 -> product=16'hFE01; a=0, b=200 -> product=16'h0000. Check add_ci=0 throughout.
- Start held high continuously with a=3, b=4 -> result 16'h000C each time; accepted again on the DONE edge; done pulses every 9 cycles.
- Start pulsed at RUN cycle 3 with different operands -> ignored; product matches the original operands.
- Reset asserted in RUN cycle 5 -> next cycle busy=0, done=0, product=0; a subsequent start completes normally.
- a=8'hFD, b=8'h05 -> unsigned build: 16'h04F1. With MUL8_SIGNED_EN: 16'hFFF1 (-15). Signed build, a=b=8'h80 -> 16'h4000.

Source files
------------

// File: rtl/mul8_seq_if.sv
// Request/result bundle for the sequential 8x8 multiplier: operands and start
// in, busy/done status and the 16-bit product out.
interface mul8_seq_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/mul8_seq.sv
// Sequential 8x8 shift-and-add multiplier that time-shares the external 8-bit
// ripple-carry adder. Define MUL8_SIGNED_EN for two's-complement operands.
module mul8_seq #(
  parameter int WIDTH = 8,
  parameter int ITER  = 8
) (
  input  logic             clk,
  input  logic             reset,
  mul8_seq_if.slave        bus,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic [WIDTH-1:0] add_y,
  input  logic             add_c
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   mcand;
  logic [3:0]         count;
  logic [2*WIDTH-1:0] product_q;

  logic               accept;
  logic               last;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] result;

  assign accept = bus.start && (state != RUN);
  assign last   = (state == RUN) && (count == 4'(ITER - 1));
  // Adder carry-out is the 9th bit of the partial sum; shift it into acc.
  assign step   = {add_c, add_y, mq[WIDTH-1:1]};

`ifdef MUL8_SIGNED_EN
  logic sign;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  assign result = sign ? (~step + {{(2*WIDTH-1){1'b0}}, 1'b1}) : step;
`else
  assign result = step;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = bus.start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      mq        <= '0;
      mcand     <= '0;
      count     <= '0;
      product_q <= '0;
`ifdef MUL8_SIGNED_EN
      sign      <= 1'b0;
`endif
    end else if (accept) begin
      acc   <= '0;
      count <= '0;
`ifdef MUL8_SIGNED_EN
      mq    <= magnitude(bus.b);
      mcand <= magnitude(bus.a);
      sign  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`else
      mq    <= bus.b;
      mcand <= bus.a;
`endif
    end else if (state == RUN) begin
      {acc, mq} <= step;
      count     <= count + 4'd1;
      if (last) product_q <= result;
    end
  end

  assign bus.product = product_q;

  // Outside RUN the adder result is ignored; B is held at zero there.
  assign add_a  = acc;
  assign add_b  = ((state == RUN) && mq[0]) ? mcand : '0;
  assign add_ci = 1'b0;

endmodule
